z80_io_responder: RTL



---
 rtl/z80_io_responder_if.sv | 36 +++
 rtl/z80_io_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/z80_io_responder_if.sv
// ============================================================================
// Module      : z80_io_responder_if
// Description : Z80 I/O bus bundle; the shared data bus is resolved here
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface z80_io_responder_if;
    logic [15:0] A;
    logic        nIORQ;
    logic        nRD;
    logic        nWR;
    logic        nM1;
    logic        nWAIT;
    logic        nINT;
    logic [7:0]  d_cpu;
    logic        d_cpu_oe;
    logic [7:0]  d_out;
    logic        d_oe;
    wire  [7:0]  D;

    // Undriven bus floats high through pull-ups; d_oe is the responder's hi-Z flag
    assign D = d_oe ? d_out : (d_cpu_oe ? d_cpu : 8'hFF);

    modport slave (
        input  A, nIORQ, nRD, nWR, nM1, D,
        output nWAIT, nINT, d_out, d_oe
    );

    modport master (
        output A, nIORQ, nRD, nWR, nM1, d_cpu, d_cpu_oe,
        input  D, nWAIT, nINT, d_oe
    );
endinterface

`default_nettype wire

// File: rtl/z80_io_responder.sv
// ============================================================================
// Module      : z80_io_responder
// Description : 4-port Z80 I/O target with wait states and mode-2 interrupt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_io_responder #(
    parameter logic [7:0] BASE_PORT   = 8'h40,
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] INT_VECTOR  = 8'hFF
) (
    input  wire              CLK,
    input  wire              nRESET,
    z80_io_responder_if.slave bus,
    input  wire              irq_req,
    output logic             irq_pending
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] c_wait_states = 3'(WAIT_STATES);
    localparam logic       c_zero_wait   = (WAIT_STATES == 0);

    state_t     r_state, w_state_next;
    logic [2:0] r_wcnt;
    logic [1:0] r_sel;
    logic       r_rd, r_wr, r_inta;
    logic [7:0] r_data, r_vector, r_count, r_d_out;
    logic       r_ie, r_pend, r_d_oe, r_nwait, r_nint;

    logic       w_hit, w_inta_req, w_idle;
    logic       w_cur_rd, w_cur_wr, w_cur_inta;
    logic [1:0] w_cur_sel;
    logic       w_enter_active, w_finish, w_write, w_pend_clr;
    logic [7:0] w_rd_mux;
    logic       w_unused_addr_hi;

    assign w_unused_addr_hi = &{1'b0, bus.A[15:8]};

    assign w_hit      = ~bus.nIORQ & bus.nM1 & (~bus.nRD | ~bus.nWR)
                        & (bus.A[7:2] == BASE_PORT[7:2]);
    assign w_inta_req = ~bus.nIORQ & ~bus.nM1;
    assign w_idle     = (r_state == S_IDLE);

    // With zero wait states ACTIVE is entered straight from the decode edge,
    // so the cycle type must come from the live bus rather than the latches.
    assign w_cur_rd   = w_idle ? (w_hit & ~bus.nRD)            : r_rd;
    assign w_cur_wr   = w_idle ? (w_hit & ~bus.nWR & bus.nRD)  : r_wr;
    assign w_cur_inta = w_idle ? w_inta_req                    : r_inta;
    assign w_cur_sel  = w_idle ? bus.A[1:0]                    : r_sel;

    always_comb begin
        w_state_next   = r_state;
        w_enter_active = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit | w_inta_req) begin
                    if (c_zero_wait) begin
                        w_state_next   = S_ACTIVE;
                        w_enter_active = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.nIORQ) begin
                    w_state_next = S_IDLE;
                end else if (r_wcnt == 3'd1) begin
                    w_state_next   = S_ACTIVE;
                    w_enter_active = 1'b1;
                end
            end
            S_ACTIVE: begin
                w_state_next = bus.nIORQ ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (bus.nIORQ) begin
                    w_state_next = S_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = r_data;
        case (w_cur_sel)
            2'd0:    w_rd_mux = r_data;
            2'd1:    w_rd_mux = {6'b0, r_pend, r_ie};
            2'd2:    w_rd_mux = r_vector;
            default: w_rd_mux = r_count;
        endcase
    end

    assign w_write    = w_enter_active & w_cur_wr;
    assign w_pend_clr = (w_write & (w_cur_sel == 2'd1) & bus.D[1])
                        | (w_finish & r_inta);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_wcnt   <= 3'd0;
            r_sel    <= 2'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_inta   <= 1'b0;
            r_data   <= 8'h00;
            r_vector <= INT_VECTOR;
            r_count  <= 8'h00;
            r_ie     <= 1'b0;
            r_pend   <= 1'b0;
            r_d_out  <= 8'h00;
            r_d_oe   <= 1'b0;
            r_nwait  <= 1'b1;
            r_nint   <= 1'b1;
        end else begin
            if (w_idle) begin
                r_wcnt <= c_wait_states;
                r_sel  <= w_cur_sel;
                r_rd   <= w_cur_rd;
                r_wr   <= w_cur_wr;
                r_inta <= w_cur_inta;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt - 3'd1;
            end

            if (w_write) begin
                case (w_cur_sel)
                    2'd0:    r_data   <= bus.D;
                    2'd1:    r_ie     <= bus.D[0];
                    2'd2:    r_vector <= bus.D;
                    default: ;
                endcase
            end

            if (w_finish & (r_rd | r_wr)) begin
                r_count <= r_count + 8'd1;
            end

            // A fresh request on the clearing edge keeps the flag set
            r_pend <= irq_req | (r_pend & ~w_pend_clr);
            r_nint <= ~(r_pend & r_ie) | (w_pend_clr & ~irq_req);

            if (w_enter_active) begin
                r_d_oe  <= w_cur_rd | w_cur_inta;
                r_d_out <= w_cur_inta ? r_vector : w_rd_mux;
            end else if (w_state_next == S_IDLE) begin
                r_d_oe <= 1'b0;
            end

            r_nwait <= (w_state_next != S_WAIT);
        end
    end

    assign bus.nWAIT  = r_nwait;
    assign bus.nINT   = r_nint;
    assign bus.d_out  = r_d_out;
    assign bus.d_oe   = r_d_oe;
    assign irq_pending = r_pend;

endmodule

`default_nettype wire
